ahb_dmem_responder: RTL
=======================

Name: ahb_dmem_responder

Overview:
- AHB-Lite subordinate (responder) data memory. It serves the lw/sw NONSEQ transfers issued by the processor's microcoded control unit.
- It captures the address phase, completes the data phase with optional wait states, and stores data in an internal word array.
- Illegal transfers get the standard two-cycle ERROR response.
- It sits on the processor's data bus opposite the core's initiator logic.

Parameters:
- ADDR_W, 32, width of HADDR.
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.
- WAIT_STATES, 0, number of HREADYOUT-low cycles inserted in every OKAY data phase (0..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- HSEL  in  1  responder select.
- HADDR  in  ADDR_W  byte address (address phase).
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 half, 010 word; others are illegal.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-wide ready; address phase is accepted only when high.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  responder ready.
- HRESP  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (async assert, sync release): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, any pending write discarded. Array contents are NOT reset.
- Accept condition: HSEL && HREADY && HTRANS[1]. On accept, register addr, write, size and offset. BUSY, IDLE or unselected transfers produce a zero-wait OKAY and no state change.
- Legality check at accept. A transfer is illegal if any of these hold:
  - HSIZE > 010;
  - it is misaligned (half with HADDR[0]=1; word with HADDR[1:0]!=0);
  - HADDR is outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4).
- Illegal transfers go to ERR1.
- Legal transfers: if WAIT_STATES=0, go to DATA_LAST; otherwise go to DATA_WAIT with the counter loaded to WAIT_STATES-1.
- States:
  - IDLE: HREADYOUT=1, HRESP=0.
  - DATA_WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; when the counter is 0, go to DATA_LAST.
  - DATA_LAST: HREADYOUT=1, HRESP=0. The transfer completes this cycle; a new accept in the same cycle goes directly to its next state (pipelined), otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept is allowed here, as in DATA_LAST. A master cancelling with IDLE sends the responder to IDLE.
- Word index = (addr - BASE_ADDR) >> 2, using $clog2(DEPTH_WORDS) bits.
- Read:
  - HRDATA carries the full addressed word (combinational from the array) in DATA_WAIT and DATA_LAST of a read. The master extracts lanes.
  - In all other states HRDATA = 0.
- Write:
  - Commits on the rising edge ending DATA_LAST; HWDATA is sampled then.
  - Byte strobes, little-endian: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all lanes.
  - Unstrobed lanes are unchanged.
  - No write occurs for ERROR transfers or for transfers aborted by reset.
- Write-then-read to the same word back-to-back: the read data phase starts after the write commit edge, so it returns the new data. No bypass is required.
- HREADY low while this slave is not in a data phase: no accept and no state change.
- Reset mid-wait: the transfer is abandoned and the outputs go to their reset values.

Decomposition:
- Shared package `ahb_pkg`:
  - HTRANS constants (IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE constants (BYTE/HALF/WORD);
  - HRESP constants (OKAY/ERROR);
  - responder state enum (IDLE, DATA_WAIT, DATA_LAST, ERR1, ERR2).
- One sub-module, `dmem_array`: a DEPTH_WORDS x 32 array with a combinational read port, a single write port, and a 4-bit byte-enable, clocked by clk.

Test Plan:
- Write word 0xDEADBEEF at 0x10 (NONSEQ, WAIT_STATES=0), then read 0x10 -> HREADYOUT stays 1, HRESP=0, read data phase HRDATA=0xDEADBEEF.
- After word 0x11223344 at 0x20, byte write HWDATA=0xAABBCCDD to 0x23 -> read 0x20 returns 0xAA223344. Then half write 0x0000_5566 to 0x20 -> read returns 0xAA225566.
- Each of the following gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), and a subsequent read of 0x04 is unchanged:
  - word write to 0x06 (misaligned);
  - read with HSIZE=011;
  - access to BASE_ADDR+0x400 with DEPTH_WORDS=256.
- WAIT_STATES=2, read 0x10 -> HREADYOUT low for exactly 2 cycles, then high with valid HRDATA. A pipelined NONSEQ write presented during DATA_LAST is accepted and itself waits 2 cycles.
- Back-to-back write 0x0000CAFE to 0x30, then read 0x30 in the next address phase -> read returns 0x0000CAFE. An interleaved BUSY/IDLE cycle gives OKAY with no side effect.
- Assert rst_n low mid DATA_WAIT of a write to 0x40 (WAIT_STATES=3) -> HREADYOUT=1, HRESP=0 and HRDATA=0 immediately. A later read of 0x40 returns the pre-write value.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and responder state/payload types for the data memory.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA_WAIT,
    ST_DATA_LAST,
    ST_ERR1,
    ST_ERR2
  } resp_state_e;

  // Address-phase attributes held for the following data phase
  typedef struct packed {
    logic       write;
    logic [2:0] size;
    logic [1:0] lane;
  } aphase_t;

  // Little-endian byte-lane strobes for a legal transfer size and byte offset
  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lane;
      HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data array: combinational read port, byte-enabled synchronous write port.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_dmem_responder.sv
// AHB-Lite responder data memory with optional wait states and two-cycle ERROR response.
module ahb_dmem_responder
  import ahb_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 3;
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH_WORDS * 4);

  resp_state_e       state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_in;
  aphase_t           ap, ap_in;
  logic              capture;
  logic              ready_n, resp_n;
  logic              accept, legal, aligned, in_range;
  logic [ADDR_W-1:0] offset;
  logic [31:0]       rdata;
  logic              we;

  // Address-phase decode: accept condition and legality of the presented transfer
  always_comb begin
    accept   = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    offset   = HADDR - BASE_ADDR;
    in_range = {1'b0, offset} < SPAN;
    idx_in   = offset[IDX_W+1:2];
    ap_in    = '{write: HWRITE, size: HSIZE, lane: HADDR[1:0]};
    aligned  = 1'b1;
    if (HSIZE == HSIZE_HALF)      aligned = ~HADDR[0];
    else if (HSIZE == HSIZE_WORD) aligned = (HADDR[1:0] == 2'b00);
    legal    = (HSIZE <= HSIZE_WORD) && aligned && in_range;
  end

  // Next-state logic; IDLE, DATA_LAST and ERR2 all admit a new address phase
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    case (state)
      ST_DATA_WAIT: begin
        if (cnt == '0) state_n = ST_DATA_LAST;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      ST_ERR1: state_n = ST_ERR2;
      default: begin
        state_n = ST_IDLE;
        if (accept) begin
          capture = 1'b1;
          if (!legal) begin
            state_n = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_n = ST_DATA_LAST;
          end else begin
            state_n = ST_DATA_WAIT;
            cnt_n   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
    endcase
    ready_n = !(state_n == ST_DATA_WAIT || state_n == ST_ERR1);
    resp_n  = (state_n == ST_ERR1 || state_n == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  end

  // State, wait counter, captured address phase and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      ap        <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      HREADYOUT <= ready_n;
      HRESP     <= resp_n;
      if (capture) begin
        idx <= idx_in;
        ap  <= ap_in;
      end
    end
  end

  assign we = (state == ST_DATA_LAST) && ap.write;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (we),
    .be    (byte_strobe(ap.size, ap.lane)),
    .waddr (idx),
    .wdata (HWDATA),
    .raddr (idx),
    .rdata (rdata)
  );

  // Read data is only driven during the data phase of a read
  assign HRDATA = ((state == ST_DATA_WAIT || state == ST_DATA_LAST) && !ap.write) ? rdata : '0;

endmodule
